// File: rtl/pio_fifo.sv
// pio_fifo: synchronous first-word-fall-through FIFO between the system bus
// and one PIO state machine. It is used as both the TX FIFO and the RX FIFO.
// It reports its occupancy and keeps sticky overflow/underflow debug flags.
// DEPTH must be a power of two and at least 2, so the pointers wrap naturally.
module pio_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pull,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_flags
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          do_push;
  logic          do_pull;
  logic          ovf_ev;
  logic          unf_ev;

  // Status decodes from the registered level only, so it is stable all cycle
  assign empty = (level_q == LW'(0));
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;

  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // Head word falls through; an empty FIFO shows zero rather than stale data
  assign dout = empty ? WIDTH'(0) : mem_q[rp_q];

  // Accept rules and next-state for pointers, level and sticky flags
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    // A push while full is still accepted when a pull frees the head slot.
    // Flush discards any strobes in the same cycle.
    do_pull = ~flush & pull & ~empty;
    do_push = ~flush & push & (~full | pull);
    ovf_ev  = ~flush & push & full & ~pull;
    unf_ev  = ~flush & pull & empty;

    // Clear first so that a coincident new event wins
    if (clr_flags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_ev) begin
      ovf_d = 1'b1;
    end
    if (unf_ev) begin
      unf_d = 1'b1;
    end

    if (flush) begin
      wp_d    = PW'(0);
      rp_d    = PW'(0);
      level_d = LW'(0);
    end else begin
      if (do_push) begin
        wp_d = wp_q + PW'(1);
      end
      if (do_pull) begin
        rp_d = rp_q + PW'(1);
      end
      unique case ({do_push, do_pull})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control registers with synchronous reset; flags survive a flush
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= PW'(0);
      rp_q    <= PW'(0);
      level_q <= LW'(0);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array; contents need no reset because level masks them
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[wp_q] <= din;
    end
  end

endmodule

// File: tb/tb_pio_fifo.sv
// Bench for pio_fifo: directed scenarios plus a random soak.
// Expectations come from a queue-based reference model.
module tb_pio_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             push = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             pull = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;
  logic             clr_flags = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;

  pio_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .din       (din),
    .pull      (pull),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .overflow  (overflow),
    .underflow (underflow),
    .clr_flags (clr_flags)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, updating the model from the strobes held across it
  task automatic tick();
    bit r  = reset;
    bit f  = flush;
    bit pu = push;
    bit pl = pull;
    bit cl = clr_flags;
    logic [WIDTH-1:0] d = din;
    int n;
    @(posedge clk);
    n = mq.size();
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (f) begin
      mq.delete();
      if (cl) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
    end else begin
      if (cl) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (pu && n == DEPTH && !pl) m_ovf = 1'b1;
      if (pl && n == 0) m_unf = 1'b1;
      if (pl && n > 0) void'(mq.pop_front());
      if (pu && (n < DEPTH || pl)) mq.push_back(d);
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; flush = 1'b0; push = 1'b0; pull = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %0b exp 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %0b exp 0", full); end
    vectors++; if (level !== LW'(0)) begin miscompares++; $display("FAIL reset_level got %0d exp 0", level); end
    vectors++; if (dout !== WIDTH'(0)) begin miscompares++; $display("FAIL reset_dout got %h exp 0", dout); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow got %0b exp 0", underflow); end
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] seq [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; din = seq[i];
      tick();
      if (i == 0) begin
        vectors++; if (dout !== 32'h11 || empty !== 1'b0) begin miscompares++; $display("FAIL first_word_latency dout %h empty %0b exp 11/0", dout, empty); end
      end
    end
    push = 1'b0;
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full got %0b exp 1", full); end
    vectors++; if (level !== LW'(4)) begin miscompares++; $display("FAIL fill_level got %0d exp 4", level); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (dout !== seq[i]) begin miscompares++; $display("FAIL drain_dout[%0d] got %h exp %h", i, dout, seq[i]); end
      pull = 1'b1;
      tick();
    end
    pull = 1'b0;
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %0b exp 1", empty); end
    vectors++; if (dout !== WIDTH'(0)) begin miscompares++; $display("FAIL drain_dout_zero got %h exp 0", dout); end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] exp_seq [4] = '{32'h22, 32'h33, 32'h44, 32'h66};
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      push = 1'b1; din = WIDTH'(i * 32'h11);
      tick();
    end
    din = 32'h55;
    tick();
    push = 1'b0;
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
    vectors++; if (level !== LW'(4)) begin miscompares++; $display("FAIL ovf_level got %0d exp 4", level); end
    vectors++; if (dout !== 32'h11) begin miscompares++; $display("FAIL ovf_head got %h exp 11", dout); end
    push = 1'b1; pull = 1'b1; din = 32'h66;
    vectors++; if (dout !== 32'h11) begin miscompares++; $display("FAIL full_pushpull_dout got %h exp 11", dout); end
    tick();
    push = 1'b0; pull = 1'b0;
    vectors++; if (level !== LW'(4) || full !== 1'b1) begin miscompares++; $display("FAIL full_pushpull_level got %0d/%0b exp 4/1", level, full); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (dout !== exp_seq[i]) begin miscompares++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, dout, exp_seq[i]); end
      pull = 1'b1;
      tick();
    end
    pull = 1'b0;
  endtask

  task automatic test_underflow();
    idle_inputs();
    pull = 1'b1;
    tick();
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL unf_flag got %0b exp 1", underflow); end
    vectors++; if (level !== LW'(0)) begin miscompares++; $display("FAIL unf_level got %0d exp 0", level); end
    push = 1'b1; din = 32'h77;
    tick();
    push = 1'b0; pull = 1'b0;
    vectors++; if (level !== LW'(1) || empty !== 1'b0) begin miscompares++; $display("FAIL empty_pushpull_level got %0d/%0b exp 1/0", level, empty); end
    vectors++; if (dout !== 32'h77) begin miscompares++; $display("FAIL empty_pushpull_dout got %h exp 77", dout); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL clr_flags got %0b%0b exp 00", overflow, underflow); end
    pull = 1'b1;
    tick();
    // A clear coinciding with a fresh underflow leaves the flag set
    clr_flags = 1'b1;
    tick();
    pull = 1'b0; clr_flags = 1'b0;
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL clr_vs_set got %0b exp 1", underflow); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  task automatic test_soak();
    logic [WIDTH-1:0] exp_dout;
    idle_inputs();
    for (int c = 0; c < 1000; c++) begin
      push = ($urandom_range(0, 99) < 55);
      pull = ($urandom_range(0, 99) < 50);
      clr_flags = ($urandom_range(0, 99) < 3);
      din = $urandom();
      tick();
      exp_dout = (mq.size() > 0) ? mq[0] : WIDTH'(0);
      vectors++;
      if (dout !== exp_dout || level !== LW'(mq.size()) ||
          empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
          overflow !== m_ovf || underflow !== m_unf) begin
        miscompares++;
        $display("FAIL soak cycle %0d got dout %h lvl %0d e%0b f%0b o%0b u%0b exp dout %h lvl %0d e%0b f%0b o%0b u%0b",
                 c, dout, level, empty, full, overflow, underflow,
                 exp_dout, mq.size(), mq.size() == 0, mq.size() == DEPTH, m_ovf, m_unf);
      end
    end
    idle_inputs();
  endtask

  task automatic test_flush_reset();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pull = 1'b1;
    tick();
    pull = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; din = $urandom();
      tick();
    end
    vectors++; if (level !== LW'(3)) begin miscompares++; $display("FAIL pre_flush_level got %0d exp 3", level); end
    flush = 1'b1; push = 1'b1; din = 32'hDEAD_BEEF;
    tick();
    flush = 1'b0; push = 1'b0;
    vectors++; if (level !== LW'(0) || empty !== 1'b1) begin miscompares++; $display("FAIL flush_level got %0d/%0b exp 0/1", level, empty); end
    vectors++; if (dout !== WIDTH'(0)) begin miscompares++; $display("FAIL flush_dout got %h exp 0", dout); end
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL flush_keeps_flag got %0b exp 1", underflow); end
    push = 1'b1; din = 32'h99;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; push = 1'b0;
    vectors++; if (underflow !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL reset_clears_flags got %0b%0b exp 00", overflow, underflow); end
    vectors++; if (level !== LW'(0) || dout !== WIDTH'(0)) begin miscompares++; $display("FAIL reset_midstream got lvl %0d dout %h exp 0/0", level, dout); end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_soak();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pio_fifo.md
# pio_fifo

Synchronous first-word-fall-through FIFO between the bus/system side and one PIO state machine. One instance serves as the TX FIFO: the system writes, and the machine's `pull`, auto-pull and `empty` consume it. A second instance serves as the RX FIFO: the machine's `push`/`dout` feed it, its `full` throttles the machine, and the system reads it. The block also provides an occupancy count and sticky overflow/underflow debug flags for the system register block.

## Interface
Parameters:
- `WIDTH`, 32: data word width.
- `DEPTH`, 4: number of entries; must be a power of two, minimum 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of contents; flags are kept (driven from the machine `restart`).
- `push`  in  1  write strobe; `din` is captured on this edge.
- `din`  in  WIDTH  write data.
- `pull`  in  1  read strobe; pops the head entry.
- `dout`  out  WIDTH  head entry, valid combinationally whenever `empty`=0.
- `empty`  out  1  level == 0.
- `full`  out  1  level == DEPTH.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a push occurred while full and no pull.
- `underflow`  out  1  sticky: a pull occurred while empty.
- `clr_flags`  in  1  clears `overflow` and `underflow`.

## Operation
- Storage is a DEPTH x WIDTH register array. Write pointer `wp`, read pointer `rp` and `level` are all registers.
- Both pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- `empty` and `full` decode from `level`, never from pointer compare.
- Accept rules, evaluated each edge:
  - `do_pull` = `pull` & ~`empty`.
  - `do_push` = `push` & (~`full` | `pull`). A simultaneous pull frees the slot, so a push while full is accepted when `pull` is also high.
- `do_push`: mem[`wp`] <= `din`; `wp` <= `wp`+1.
- `do_pull`: `rp` <= `rp`+1.
- `level`:
  - +1 on push only.
  - -1 on pull only.
  - Unchanged on both or neither.
- Push and pull together while empty: the pull is rejected and `underflow` is set. The push is accepted, and `level` becomes 1.
- Rejected push (full, no pull): data is dropped, storage is not modified, and `overflow` <= 1.
- Rejected pull (empty): `rp` is unchanged and `underflow` <= 1.
- `dout` = mem[`rp`] when ~`empty`, and is forced to 0 when `empty`. It never shows stale data.
- `clr_flags` clears both flags. If it coincides with a new overflow or underflow event, the set wins.
- `flush` zeroes `wp`, `rp` and `level`, and takes priority over `push` and `pull` in the same cycle. Flags are unaffected.
- `reset` zeroes `wp`, `rp`, `level`, `overflow` and `underflow`. Array contents need no reset.

## Timing
- Reset values: `empty`=1, `full`=0, `level`=0, `overflow`=0, `underflow`=0, `dout`=0.
- Write-to-read latency is one cycle. A word pushed at edge N appears on `dout` with `empty`=0 after edge N.
- Reads are first-word-fall-through. The consumer samples `dout` in the same cycle it asserts `pull`, and the next entry appears after that edge. The machine's OSR load relies on this.
- `full`, `empty` and `level` are registered-derived. They change only on clock edges and are stable for the whole cycle, so they can safely be used in the consumer's combinational `waiting` stall.
- Strobes are single-cycle qualifiers. A strobe held for k cycles performs k operations; the FIFO does not edge-detect.
- Throughput is one push and one pull per cycle at every level, with no bubbles at wrap-around.
- Reset or flush asserted mid-stream takes effect at that edge. A push or pull in the same cycle is discarded.

## Test plan
- Reset, then idle: `empty`=1, `full`=0, `level`=0, `dout`=0, both flags 0.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles (DEPTH=4), then pull 4 times:
  - `full`=1 after the 4th push.
  - `dout` reads 0x11, 0x22, 0x33, 0x44 in order.
  - `empty`=1 after the last pull.
- Overflow and concurrent access at full:
  - While full, push 0x55 alone: `overflow`=1, `level` stays 4, and the contents are unchanged.
  - Next cycle, push 0x66 and pull together: `dout` was 0x11, `level` stays 4, and 0x66 later emerges last.
- Underflow with concurrent push while empty:
  - Pull while empty: `underflow`=1, `level` stays 0.
  - Then push 0x77 and pull together: the push is accepted, `level`=1, `dout`=0x77.
  - Pulse `clr_flags`: both flags return to 0.
- Wrap-around soak:
  - 1000 cycles of random push/pull against a reference queue.
  - Data order, `level`, `empty` and `full` match every cycle, with both pointers wrapping many times.
- Flush and reset mid-stream:
  - With `level`=3, assert `flush` together with `push`: `level`=0, `empty`=1, `dout`=0, and the flags are retained.
  - Then assert `reset`: both flags clear.
